sprite_buffer_writer: RTL and testbench

- Fills the packed 1-bit-per-channel sprite planes that the VGA sprite reader consumes.
- Accepts a raster-ordered pixel stream (row-major, top-left first) over a valid/ready handshake and writes each pixel into its plane bit, index = y*LARGURA + x.
- Sits between the sprite source (ROM sequencer or host loader) and the VGA read path.
- Signals completion so the scene logic can enable drawing.

---
 rtl/sprite_buffer_writer.sv | 160 ++++++++++++++++
 tb/tb_sprite_buffer_writer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_buffer_writer.sv
// sprite_buffer_writer
//
// Loads a raster-ordered pixel stream into three packed 1-bit colour planes
// (R, G, B) that the VGA sprite reader consumes. Each accepted pixel lands at
// plane index y*W + x. With SPRITE_MIRROR_EN defined, a MIRROR latched at START
// stores each row horizontally flipped: index y*W + (W-1-x).
//
// Optional feature macro: SPRITE_MIRROR_EN (undefined: MIRROR is ignored).
//
// Ports:
//   CLK             system clock, rising edge
//   reset           synchronous active-low reset
//   START           one-cycle load request (IDLE only)
//   ABORT           cancel an in-progress load
//   LARGURA_OBJETO  sprite width, sampled at START
//   ALTURA_OBJETO   sprite height, sampled at START
//   MIRROR          horizontal-flip request, sampled at START
//   PIXEL_RGB       {R,G,B} of the current pixel
//   PIXEL_VALID     source presents a pixel
//   PIXEL_READY     writer accepts a pixel (LOAD)
//   BUFFER_R/G/B    colour planes [0:BUFFER_BITS-1]
//   BUSY            high while loading
//   DONE            one-cycle pulse after the last pixel
//   ERROR           one-cycle pulse on START with invalid dimensions
module sprite_buffer_writer #(
  parameter int unsigned BUFFER_BITS = 255
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic [9:0]             LARGURA_OBJETO,
  input  logic [9:0]             ALTURA_OBJETO,
  input  logic                   MIRROR,
  input  logic [2:0]             PIXEL_RGB,
  input  logic                   PIXEL_VALID,
  output logic                   PIXEL_READY,
  output logic [0:BUFFER_BITS-1] BUFFER_R,
  output logic [0:BUFFER_BITS-1] BUFFER_G,
  output logic [0:BUFFER_BITS-1] BUFFER_B,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERROR
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                 state_q;
  logic [9:0]             w_q, h_q, x_q, y_q;
  logic                   mirror_q;
  logic                   error_q;
  logic [0:BUFFER_BITS-1] r_q, g_q, b_q;

  logic [19:0]            area;
  logic                   dims_ok;
  logic [9:0]             col;
  logic [19:0]            idx;
  logic                   row_end, last_row;
  logic [0:BUFFER_BITS-1] r_wr, g_wr, b_wr;

`ifndef SPRITE_MIRROR_EN
  logic unused_mirror_q;
  assign unused_mirror_q = mirror_q;
`endif

  always_comb begin
    // Full 20-bit product so oversized sprites can never alias into range.
    area    = {10'd0, LARGURA_OBJETO} * {10'd0, ALTURA_OBJETO};
    dims_ok = (LARGURA_OBJETO != 10'd0) && (ALTURA_OBJETO != 10'd0) &&
              ({12'd0, area} <= BUFFER_BITS);

`ifdef SPRITE_MIRROR_EN
    col = mirror_q ? (w_q - 10'd1 - x_q) : x_q;
`else
    col = x_q;
`endif
    idx = ({10'd0, y_q} * {10'd0, w_q}) + {10'd0, col};

    row_end  = (x_q == w_q - 10'd1);
    last_row = (y_q == h_q - 10'd1);

    // Decoded write: compare against every bit position rather than a
    // dynamic select, so the 20-bit index needs no truncation.
    r_wr = r_q;
    g_wr = g_q;
    b_wr = b_q;
    for (int i = 0; i < BUFFER_BITS; i++) begin
      if (idx == 20'(i)) begin
        r_wr[i] = PIXEL_RGB[2];
        g_wr[i] = PIXEL_RGB[1];
        b_wr[i] = PIXEL_RGB[0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q  <= StIdle;
      w_q      <= '0;
      h_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mirror_q <= 1'b0;
      error_q  <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (START) begin
            if (dims_ok) begin
              w_q      <= LARGURA_OBJETO;
              h_q      <= ALTURA_OBJETO;
              mirror_q <= MIRROR;
              x_q      <= '0;
              y_q      <= '0;
              r_q      <= '0;
              g_q      <= '0;
              b_q      <= '0;
              state_q  <= StLoad;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          // ABORT wins over a same-cycle transfer.
          if (ABORT) begin
            state_q <= StIdle;
          end else if (PIXEL_VALID) begin
            r_q <= r_wr;
            g_q <= g_wr;
            b_q <= b_wr;
            if (!row_end) begin
              x_q <= x_q + 10'd1;
            end else if (!last_row) begin
              x_q <= '0;
              y_q <= y_q + 10'd1;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign PIXEL_READY = (state_q == StLoad);
  assign BUSY        = (state_q == StLoad);
  assign DONE        = (state_q == StDone);
  assign ERROR       = error_q;
  assign BUFFER_R    = r_q;
  assign BUFFER_G    = g_q;
  assign BUFFER_B    = b_q;

endmodule

// File: tb/tb_sprite_buffer_writer.sv
module tb_sprite_buffer_writer;

  localparam int unsigned BB = 255;
`ifdef SPRITE_MIRROR_EN
  localparam bit MirrorBuild = 1'b1;
`else
  localparam bit MirrorBuild = 1'b0;
`endif

  logic          CLK, reset, START, ABORT, MIRROR, PIXEL_VALID;
  logic [9:0]    LARGURA_OBJETO, ALTURA_OBJETO;
  logic [2:0]    PIXEL_RGB;
  logic          PIXEL_READY, BUSY, DONE, ERROR;
  logic [0:BB-1] BUFFER_R, BUFFER_G, BUFFER_B;

  sprite_buffer_writer #(.BUFFER_BITS(BB)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .START         (START),
    .ABORT         (ABORT),
    .LARGURA_OBJETO(LARGURA_OBJETO),
    .ALTURA_OBJETO (ALTURA_OBJETO),
    .MIRROR        (MIRROR),
    .PIXEL_RGB     (PIXEL_RGB),
    .PIXEL_VALID   (PIXEL_VALID),
    .PIXEL_READY   (PIXEL_READY),
    .BUFFER_R      (BUFFER_R),
    .BUFFER_G      (BUFFER_G),
    .BUFFER_B      (BUFFER_B),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .ERROR         (ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         idx;
    logic [2:0] rgb;
  } wr_t;

  wr_t           sb[$];
  logic [0:BB-1] er, eg, eb;
  int            tests, fails;
  int            bw, bh, bx, by, nwr, last_idx;
  bit            bm;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [BB:0] obs, input logic [BB:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_planes(input string tag);
    check({tag, "_r"}, BUFFER_R, er);
    check({tag, "_g"}, BUFFER_G, eg);
    check({tag, "_b"}, BUFFER_B, eb);
  endtask

  function automatic int exp_idx();
    if (bm && MirrorBuild) return by * bw + (bw - 1 - bx);
    return by * bw + bx;
  endfunction

  task automatic do_start(input int w, input int h, input bit m);
    LARGURA_OBJETO = 10'(w);
    ALTURA_OBJETO  = 10'(h);
    MIRROR         = m;
    START          = 1'b1;
    tick();
    START = 1'b0;
    if (w != 0 && h != 0 && w * h <= BB) begin
      er = '0; eg = '0; eb = '0;
      bw = w; bh = h; bx = 0; by = 0; bm = m;
    end
  endtask

  // One cycle of stimulus; expected write pushed at drive, popped after the edge.
  task automatic step(input logic v, input logic [2:0] rgb, output bit hs);
    wr_t e;
    PIXEL_VALID = v;
    PIXEL_RGB   = rgb;
    hs = v && PIXEL_READY && !ABORT;
    if (hs) begin
      e.idx = exp_idx();
      e.rgb = rgb;
      sb.push_back(e);
    end
    tick();
    if (hs) begin
      e = sb.pop_front();
      check("pixel_write", {253'd0, BUFFER_R[e.idx], BUFFER_G[e.idx], BUFFER_B[e.idx]},
            {253'd0, e.rgb});
      er[e.idx] = e.rgb[2]; eg[e.idx] = e.rgb[1]; eb[e.idx] = e.rgb[0];
      nwr++;
      last_idx = e.idx;
      if (bx < bw - 1) bx++;
      else begin bx = 0; by++; end
    end
  endtask

  task automatic send_pixel(input logic [2:0] rgb);
    bit hs;
    hs = 1'b0;
    for (int n = 0; n < 16 && !hs; n++) step(1'b1, rgb, hs);
    if (!hs) check("handshake_timeout", 1, 0);
  endtask

  logic [2:0] pat [8];
  logic [7:0] slice;
  bit         hs_t, seen_done;
  int         cyc;

  initial begin
    tests = 0; fails = 0; nwr = 0; last_idx = -1;
    bw = 1; bh = 1; bx = 0; by = 0; bm = 1'b0;
    er = '0; eg = '0; eb = '0;
    reset = 1'b0; START = 1'b0; ABORT = 1'b0; MIRROR = 1'b0;
    LARGURA_OBJETO = '0; ALTURA_OBJETO = '0; PIXEL_RGB = '0; PIXEL_VALID = 1'b0;
    pat = '{3'd7, 3'd0, 3'd4, 3'd2, 3'd1, 3'd3, 3'd5, 3'd6};

    // Reset state.
    tick(); tick();
    check("rst_ready", PIXEL_READY, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_error", ERROR, 0);
    check_planes("rst");
    reset = 1'b1;
    tick();

    // 4x2 load, VALID held high.
    do_start(4, 2, 1'b0);
    check("t1_busy", BUSY, 1);
    check("t1_ready", PIXEL_READY, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("t1_done_early", DONE, 0);
      send_pixel(pat[i]);
    end
    check("t1_done", DONE, 1);
    check("t1_done_busy", BUSY, 0);
    check("t1_done_ready", PIXEL_READY, 0);
    PIXEL_VALID = 1'b0;
    tick();
    check("t1_done_pulse", DONE, 0);
    slice = BUFFER_R[0:7];
    check("t1_r8", slice, 8'b10100011);  // R = RGB[2] of 7,0,4,2,1,3,5,6
    slice = BUFFER_G[0:7];
    check("t1_g8", slice, 8'b10010101);
    slice = BUFFER_B[0:7];
    check("t1_b8", slice, 8'b10001110);
    check_planes("t1");

    // Invalid dimensions: 256 > 255, then W=0.
    do_start(16, 16, 1'b0);
    check("t2_error", ERROR, 1);
    check("t2_ready", PIXEL_READY, 0);
    check("t2_busy", BUSY, 0);
    check_planes("t2");
    tick();
    check("t2_error_pulse", ERROR, 0);
    do_start(0, 5, 1'b0);
    check("t2_w0_error", ERROR, 1);
    check("t2_w0_busy", BUSY, 0);
    check_planes("t2_w0");
    tick();
    check("t2_w0_error_pulse", ERROR, 0);

    // 15x17 = 255 bits, VALID toggled.
    do_start(15, 17, 1'b0);
    nwr = 0; seen_done = 1'b0;
    for (cyc = 0; cyc < 1200 && !seen_done; cyc++) begin
      step(cyc[0], 3'($urandom_range(7, 0)), hs_t);
      seen_done = DONE;
    end
    check("t3_done_seen", seen_done, 1);
    check("t3_writes", nwr, 255);
    check("t3_last_idx", last_idx, 254);
    for (int i = 0; i < 4; i++) step(1'b1, 3'd7, hs_t);
    PIXEL_VALID = 1'b0;
    check("t3_extra_writes", nwr, 255);
    check("t3_idle_ready", PIXEL_READY, 0);
    check_planes("t3");

    // Abort after 4 transfers, same cycle as VALID.
    do_start(3, 3, 1'b0);
    for (int i = 0; i < 4; i++) send_pixel(3'd7);
    ABORT = 1'b1;
    PIXEL_VALID = 1'b1;
    PIXEL_RGB = 3'd7;
    tick();
    ABORT = 1'b0;
    PIXEL_VALID = 1'b0;
    check("t4_busy", BUSY, 0);
    check("t4_ready", PIXEL_READY, 0);
    check("t4_done", DONE, 0);
    check("t4_idx4_r", BUFFER_R[4], 0);
    check_planes("t4");
    seen_done = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); seen_done = seen_done | DONE; end
    check("t4_no_done", seen_done, 0);

    // Mirror: W=4, H=1, RGB 4,0,0,0.
    do_start(4, 1, 1'b1);
    send_pixel(3'd4);
    for (int i = 0; i < 3; i++) send_pixel(3'd0);
    PIXEL_VALID = 1'b0;
    check("t5_done", DONE, 1);
    tick();
`ifdef SPRITE_MIRROR_EN
    check("t5_r3", BUFFER_R[3], 1);
    check("t5_r0", BUFFER_R[0], 0);
`else
    check("t5_r0", BUFFER_R[0], 1);
    check("t5_r3", BUFFER_R[3], 0);
`endif
    check_planes("t5");

    // Reset mid-load after 2 transfers.
    do_start(3, 3, 1'b0);
    send_pixel(3'd7);
    send_pixel(3'd5);
    reset = 1'b0;
    PIXEL_VALID = 1'b1;
    tick();
    PIXEL_VALID = 1'b0;
    er = '0; eg = '0; eb = '0;
    check("t6_busy", BUSY, 0);
    check("t6_ready", PIXEL_READY, 0);
    check_planes("t6_rst");
    reset = 1'b1;
    tick();
    do_start(2, 2, 1'b0);
    check("t6_reload_busy", BUSY, 1);
    send_pixel(3'd1);
    send_pixel(3'd2);
    send_pixel(3'd4);
    send_pixel(3'd7);
    PIXEL_VALID = 1'b0;
    check("t6_reload_done", DONE, 1);
    tick();
    check_planes("t6_reload");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
